// File: rtl/shift_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : shift_arbiter
//  Description : Two-port round-robin sequencer for the shared shift unit.
//                Accepts shift requests over valid/ready, drives the
//                combinational shifter from registered operands, captures
//                its result and returns it with the requester id over a
//                backpressured response channel.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                   clock, all state on rising edge
//    rst_n                 asynchronous active-low reset
//    req{0,1}_valid        request present on port 0 / 1
//    req{0,1}_ready        request accepted this cycle
//    req{0,1}_src1         shift operand
//    req{0,1}_src2         shift amount source
//    req{0,1}_ctrl         op: 0 SRAW, 1 SRLW, 2 SLLW, 3 SRL, 4 SLL, 5 SRA
//    sh_src1/src2/ctrl     registered operands to the shifter
//    sh_out                shifter result (combinational from sh_*)
//    resp_valid/ready      response handshake
//    resp_data             captured shifter result
//    resp_id               requester that issued the op
//    resp_err              op code was illegal (> 5), result forced to 0
// ============================================================================
module shift_arbiter #(
    parameter int XLEN   = 64,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [XLEN-1:0]   req0_src1,
    input  logic [XLEN-1:0]   req0_src2,
    input  logic [CTRL_W-1:0] req0_ctrl,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [XLEN-1:0]   req1_src1,
    input  logic [XLEN-1:0]   req1_src2,
    input  logic [CTRL_W-1:0] req1_ctrl,
    output logic [XLEN-1:0]   sh_src1,
    output logic [XLEN-1:0]   sh_src2,
    output logic [CTRL_W-1:0] sh_ctrl,
    input  logic [XLEN-1:0]   sh_out,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_data,
    output logic              resp_id,
    output logic              resp_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [CTRL_W-1:0] CTRL_LAST_W   = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] CTRL_LAST_OK  = CTRL_W'(5);
    localparam logic [CTRL_W-1:0] CTRL_RESET    = '1;

    state_t            state;
    state_t            next_state;
    logic              prio;
    logic [XLEN-1:0]   op_src1;
    logic [XLEN-1:0]   op_src2;
    logic [CTRL_W-1:0] op_ctrl;
    logic              op_id;

    logic              window;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic              fire;
    logic              sel_id;
    logic [XLEN-1:0]   sel_src1;
    logic [XLEN-1:0]   sel_src2;
    logic [CTRL_W-1:0] sel_ctrl;

    // Word ops use a 5-bit amount, doubleword ops a 6-bit amount. Illegal
    // ops pass src2 through untouched; the shifter yields 0 for them anyway.
    function automatic logic [XLEN-1:0] mask_src2(input logic [CTRL_W-1:0] c,
                                                  input logic [XLEN-1:0]   s);
        logic [XLEN-1:0] m;
        m = '0;
        if (c <= CTRL_LAST_W) begin
            m[4:0] = s[4:0];
        end else if (c <= CTRL_LAST_OK) begin
            m[5:0] = s[5:0];
        end else begin
            m = s;
        end
        return m;
    endfunction

    // ------------------------------------------------------------------
    // Arbitration: new work is taken in IDLE, or in RESP when the current
    // response leaves this cycle, so the op registers are never overwritten
    // while a result is still being produced.
    // ------------------------------------------------------------------
    assign window     = (state == IDLE) || ((state == RESP) && resp_ready);
    assign grant0     = req0_valid && (!req1_valid || !prio);
    assign grant1     = req1_valid && (!req0_valid ||  prio);
    assign req0_ready = window && grant0;
    assign req1_ready = window && grant1;

    assign accept     = req0_ready || req1_ready;
    assign resp_valid = (state == RESP);
    assign fire       = resp_valid && resp_ready;

    assign sel_id   = req1_ready;
    assign sel_src1 = sel_id ? req1_src1 : req0_src1;
    assign sel_src2 = sel_id ? req1_src2 : req0_src2;
    assign sel_ctrl = sel_id ? req1_ctrl : req0_ctrl;

    assign sh_src1 = op_src1;
    assign sh_src2 = op_src2;
    assign sh_ctrl = op_ctrl;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = EXEC;
            EXEC: next_state = RESP;
            RESP: begin
                if (fire) begin
                    next_state = accept ? EXEC : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Operand registers and round-robin pointer, updated only on accept
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio    <= 1'b0;
            op_src1 <= '0;
            op_src2 <= '0;
            op_ctrl <= CTRL_RESET;
            op_id   <= 1'b0;
        end else if (accept) begin
            prio    <= ~sel_id;
            op_src1 <= sel_src1;
            op_src2 <= mask_src2(sel_ctrl, sel_src2);
            op_ctrl <= sel_ctrl;
            op_id   <= sel_id;
        end
    end

    // ------------------------------------------------------------------
    // Response registers: loaded at the end of EXEC, held through RESP
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_data <= '0;
            resp_id   <= 1'b0;
            resp_err  <= 1'b0;
        end else if (state == EXEC) begin
            resp_data <= sh_out;
            resp_id   <= op_id;
            resp_err  <= (op_ctrl > CTRL_LAST_OK);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_arbiter
//  Description : Directed self-checking bench for shift_arbiter, with a
//                behavioural model of the shared shifter on the sh_* bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_arbiter;

    localparam int XLEN   = 64;
    localparam int CTRL_W = 4;

    logic              clk;
    logic              rst_n;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [XLEN-1:0]   req0_src1, req0_src2, req1_src1, req1_src2;
    logic [CTRL_W-1:0] req0_ctrl, req1_ctrl;
    logic [XLEN-1:0]   sh_src1, sh_src2, sh_out;
    logic [CTRL_W-1:0] sh_ctrl;
    logic              resp_valid, resp_ready, resp_id, resp_err;
    logic [XLEN-1:0]   resp_data;

    int checks = 0;
    int errors = 0;

    shift_arbiter #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_src1  (req0_src1),
        .req0_src2  (req0_src2),
        .req0_ctrl  (req0_ctrl),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_src1  (req1_src1),
        .req1_src2  (req1_src2),
        .req1_ctrl  (req1_ctrl),
        .sh_src1    (sh_src1),
        .sh_src2    (sh_src2),
        .sh_ctrl    (sh_ctrl),
        .sh_out     (sh_out),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shifter model
    logic [31:0] lo;
    always_comb begin
        lo     = '0;
        sh_out = '0;
        case (sh_ctrl)
            4'd0: begin
                lo     = 32'($signed(sh_src1[31:0]) >>> sh_src2[4:0]);
                sh_out = {{32{lo[31]}}, lo};
            end
            4'd1: begin
                lo     = sh_src1[31:0] >> sh_src2[4:0];
                sh_out = {{32{lo[31]}}, lo};
            end
            4'd2: begin
                lo     = sh_src1[31:0] << sh_src2[4:0];
                sh_out = {{32{lo[31]}}, lo};
            end
            4'd3: sh_out = sh_src1 >> sh_src2[5:0];
            4'd4: sh_out = sh_src1 << sh_src2[5:0];
            4'd5: sh_out = 64'($signed(sh_src1) >>> sh_src2[5:0]);
            default: sh_out = '0;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [63:0] s1, input logic [63:0] s2,
                          input logic [3:0] c);
        req0_valid = v; req0_src1 = s1; req0_src2 = s2; req0_ctrl = c;
    endtask

    task automatic drive1(input logic v, input logic [63:0] s1, input logic [63:0] s2,
                          input logic [3:0] c);
        req1_valid = v; req1_src1 = s1; req1_src2 = s2; req1_ctrl = c;
    endtask

    initial begin
        rst_n = 1'b0;
        resp_ready = 1'b0;
        drive0(1'b0, '0, '0, 4'd0);
        drive1(1'b0, '0, '0, 4'd0);
        tick(); tick();

        // ---------------- reset values
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_resp_data",  resp_data, 64'd0);
        check("rst_resp_id",    {63'd0, resp_id}, 64'd0);
        check("rst_resp_err",   {63'd0, resp_err}, 64'd0);
        check("rst_sh_src1",    sh_src1, 64'd0);
        check("rst_sh_src2",    sh_src2, 64'd0);
        check("rst_sh_ctrl",    {60'd0, sh_ctrl}, 64'hF);
        rst_n = 1'b1;
        #1;
        check("idle_ready0", {63'd0, req0_ready}, 64'd0);

        // ---------------- SRLW on port 0, latency
        drive0(1'b1, 64'h0000_0000_8000_0000, 64'd4, 4'd1);
        #1;
        check("t1_ready0", {63'd0, req0_ready}, 64'd1);
        check("t1_ready1", {63'd0, req1_ready}, 64'd0);
        tick();
        drive0(1'b0, '0, '0, 4'd0);
        check("t1_exec_valid", {63'd0, resp_valid}, 64'd0);
        check("t1_sh_src2",    sh_src2, 64'd4);
        check("t1_sh_ctrl",    {60'd0, sh_ctrl}, 64'd1);
        tick();
        check("t1_resp_valid", {63'd0, resp_valid}, 64'd1);
        check("t1_resp_data",  resp_data, 64'h0000_0000_0800_0000);
        check("t1_resp_id",    {63'd0, resp_id}, 64'd0);
        check("t1_resp_err",   {63'd0, resp_err}, 64'd0);
        resp_ready = 1'b1;
        tick();
        check("t1_back_idle", {63'd0, resp_valid}, 64'd0);

        // ---------------- SRAW on port 1, masked amount
        drive1(1'b1, 64'hFFFF_FFFF_8000_0000, 64'h24, 4'd0);
        #1;
        check("t3_ready1", {63'd0, req1_ready}, 64'd1);
        tick();
        drive1(1'b0, '0, '0, 4'd0);
        check("t3_sh_src2", sh_src2, 64'd4);
        tick();
        check("t3_resp_valid", {63'd0, resp_valid}, 64'd1);
        check("t3_resp_data",  resp_data, 64'hFFFF_FFFF_F800_0000);
        check("t3_resp_id",    {63'd0, resp_id}, 64'd1);
        tick();

        // ---------------- both valid, alternating grants, 2-cycle cadence
        drive0(1'b1, 64'd1, 64'd4, 4'd4);                    // SLL -> 0x10
        drive1(1'b1, 64'h8000_0000_0000_0000, 64'd4, 4'd3);  // SRL -> 0x0800...
        #1;
        for (int i = 0; i < 8; i++) begin
            check("rr_ready0", {63'd0, req0_ready}, {63'd0, (i % 2) == 0});
            check("rr_ready1", {63'd0, req1_ready}, {63'd0, (i % 2) == 1});
            if (i > 0) begin
                check("rr_resp_valid", {63'd0, resp_valid}, 64'd1);
                check("rr_resp_id",    {63'd0, resp_id}, {63'd0, (i % 2) == 0});
                check("rr_resp_data",  resp_data,
                      ((i % 2) == 0) ? 64'h0800_0000_0000_0000 : 64'h10);
            end
            tick();
            check("rr_exec_valid", {63'd0, resp_valid}, 64'd0);
            check("rr_exec_ready", {62'd0, req0_ready, req1_ready}, 64'd0);
            tick();
        end
        drive0(1'b0, '0, '0, 4'd0);
        drive1(1'b0, '0, '0, 4'd0);
        #1;
        check("rr_last_valid", {63'd0, resp_valid}, 64'd1);
        check("rr_last_id",    {63'd0, resp_id}, 64'd1);
        check("rr_last_data",  resp_data, 64'h0800_0000_0000_0000);
        tick();

        // ---------------- backpressure with SLL 63
        drive0(1'b1, 64'd1, 64'd63, 4'd4);
        #1;
        check("bp_ready0", {63'd0, req0_ready}, 64'd1);
        tick();
        resp_ready = 1'b0;
        drive0(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd8, 4'd3);
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp_hold_ready0", {63'd0, req0_ready}, 64'd0);
            check("bp_hold_valid",  {63'd0, resp_valid}, 64'd1);
            check("bp_hold_data",   resp_data, 64'h8000_0000_0000_0000);
            check("bp_hold_id",     {63'd0, resp_id}, 64'd0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        check("bp_release_ready0", {63'd0, req0_ready}, 64'd1);
        tick();
        check("bp_exec_valid", {63'd0, resp_valid}, 64'd0);
        check("bp_sh_ctrl",    {60'd0, sh_ctrl}, 64'd3);
        drive0(1'b1, 64'd5, 64'd3, 4'd7);
        tick();
        check("srl_resp_data", resp_data, 64'h00FF_FFFF_FFFF_FFFF);
        check("srl_resp_err",  {63'd0, resp_err}, 64'd0);

        // ---------------- illegal op accepted in the same cycle
        check("ill_ready0", {63'd0, req0_ready}, 64'd1);
        tick();
        drive0(1'b0, '0, '0, 4'd0);
        check("ill_sh_src2", sh_src2, 64'd3);
        tick();
        check("ill_resp_valid", {63'd0, resp_valid}, 64'd1);
        check("ill_resp_data",  resp_data, 64'd0);
        check("ill_resp_err",   {63'd0, resp_err}, 64'd1);
        tick();

        // ---------------- reset during EXEC
        drive0(1'b1, 64'd1, 64'd1, 4'd4);
        tick();
        drive0(1'b0, '0, '0, 4'd0);
        check("mr_in_exec", {63'd0, resp_valid}, 64'd0);
        rst_n = 1'b0;
        #1;
        check("mr_sh_ctrl",    {60'd0, sh_ctrl}, 64'hF);
        check("mr_resp_data",  resp_data, 64'd0);
        tick();
        check("mr_resp_valid", {63'd0, resp_valid}, 64'd0);
        rst_n = 1'b1;
        tick();
        check("mr_no_resp", {63'd0, resp_valid}, 64'd0);
        drive0(1'b1, 64'd1, 64'd31, 4'd2);            // SLLW -> sign-extended
        drive1(1'b1, 64'd1, 64'd1, 4'd4);
        #1;
        check("mr_prio_ready0", {63'd0, req0_ready}, 64'd1);
        check("mr_prio_ready1", {63'd0, req1_ready}, 64'd0);
        tick();
        drive0(1'b0, '0, '0, 4'd0);
        drive1(1'b0, '0, '0, 4'd0);
        tick();
        check("mr_resp_valid2", {63'd0, resp_valid}, 64'd1);
        check("mr_resp_data2",  resp_data, 64'hFFFF_FFFF_8000_0000);
        check("mr_resp_id2",    {63'd0, resp_id}, 64'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
